// File: rtl/class_sum_accumulator.sv
// Streams clause chunks class by class and accumulates one signed vote per class.
// Optional macro CSUM_SATURATE_EN clamps each add instead of wrapping.
module class_sum_accumulator #(
    parameter int CLASS_NUM         = 10,
    parameter int CLAUSES_PER_CLASS = 100,
    parameter int CHUNK_WIDTH       = 4,
    parameter int WEIGHT_LENGTH     = 14
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clause_valid,
    output logic                            clause_ready,
    input  logic [CHUNK_WIDTH-1:0]          clause_data,
    input  logic                            clause_last,
    output logic signed [WEIGHT_LENGTH-1:0] c_sum [CLASS_NUM],
    output logic                            its_business_time,
    output logic                            frame_err
);

    localparam int BEATS = CLAUSES_PER_CLASS / CHUNK_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CLW   = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
`ifdef CSUM_SATURATE_EN
    localparam int SW    = WEIGHT_LENGTH + 1;
    localparam logic signed [SW-1:0] SMAX =
        SW'((1 <<< (WEIGHT_LENGTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN =
        SW'(-(1 <<< (WEIGHT_LENGTH - 1)));
`else
    localparam int SW    = WEIGHT_LENGTH;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [BW-1:0]  beat_q, beat_d;
    logic [CLW-1:0] cls_q, cls_d;

    logic signed [WEIGHT_LENGTH-1:0] acc_q  [CLASS_NUM];
    logic signed [WEIGHT_LENGTH-1:0] acc_d  [CLASS_NUM];
    logic signed [WEIGHT_LENGTH-1:0] csum_q [CLASS_NUM];

    logic ready_q, ready_d;
    logic bt_q, bt_d;
    logic err_q, err_d;

    logic accept;
    logic beat_last;
    logic class_last;
    logic frame_end;

    logic signed [SW-1:0]            delta;
    logic signed [SW-1:0]            base;
    logic signed [SW-1:0]            sum_ext;
    logic signed [WEIGHT_LENGTH-1:0] sum_nxt;

    assign accept     = clause_valid && ready_q;
    assign beat_last  = (beat_q == BW'(BEATS - 1));
    assign class_last = (cls_q == CLW'(CLASS_NUM - 1));
    assign frame_end  = accept && beat_last && class_last;

    // Vote of one chunk: even clauses count up, odd clauses count down
    always_comb begin
        delta = '0;
        for (int k = 0; k < CHUNK_WIDTH; k++) begin
            if (clause_data[k]) begin
                if ((k % 2) == 0) delta = delta + SW'(1);
                else              delta = delta - SW'(1);
            end
        end
    end

    // First beat of a class loads, later beats add onto the running sum
    always_comb begin
        base = '0;
        if (beat_q != '0) begin
`ifdef CSUM_SATURATE_EN
            base = {acc_q[cls_q][WEIGHT_LENGTH-1], acc_q[cls_q]};
`else
            base = acc_q[cls_q];
`endif
        end
        sum_ext = base + delta;
`ifdef CSUM_SATURATE_EN
        if (sum_ext > SMAX)      sum_nxt = SMAX[WEIGHT_LENGTH-1:0];
        else if (sum_ext < SMIN) sum_nxt = SMIN[WEIGHT_LENGTH-1:0];
        else                     sum_nxt = sum_ext[WEIGHT_LENGTH-1:0];
`else
        sum_nxt = sum_ext;
`endif
    end

    // Write the updated sum back into the active class slot
    always_comb begin
        acc_d = acc_q;
        if (accept) acc_d[cls_q] = sum_nxt;
    end

    // Beat/class position and sticky clause_last consistency check
    always_comb begin
        beat_d = beat_q;
        cls_d  = cls_q;
        if (accept) begin
            if (beat_last) begin
                beat_d = '0;
                cls_d  = class_last ? '0 : cls_q + CLW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
        err_d = err_q;
        if (accept && (clause_last != (beat_last && class_last))) begin
            err_d = 1'b1;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = ACCUM;
            ACCUM:   if (frame_end) state_d = HOLD;
            HOLD:                   state_d = DONE;
            DONE:    if (accept)    state_d = ACCUM;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        ready_d = (state_d != HOLD);
        bt_d    = (state_d == HOLD) || (state_d == DONE);
    end

    // State, counters, flags and accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cls_q   <= '0;
            ready_q <= 1'b0;
            bt_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < CLASS_NUM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cls_q   <= cls_d;
            ready_q <= ready_d;
            bt_q    <= bt_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    // Result snapshot, taken only as the final beat lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                csum_q[i] <= '0;
            end
        end else if (frame_end) begin
            csum_q <= acc_d;
        end
    end

    assign c_sum             = csum_q;
    assign clause_ready      = ready_q;
    assign its_business_time = bt_q;
    assign frame_err         = err_q;

endmodule

// File: tb/tb_class_sum_accumulator.sv
// Bench for class_sum_accumulator: small-config model plus directed frames.
// A second instance covers the wrap / CSUM_SATURATE_EN overflow case.
module tb_class_sum_accumulator;

    localparam int NC    = 3;
    localparam int CPC   = 4;
    localparam int CW    = 2;
    localparam int WL    = 8;
    localparam int BEATS = CPC / CW;
    localparam int TOTAL = NC * BEATS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clause_valid;
    logic          clause_ready;
    logic [CW-1:0] clause_data;
    logic          clause_last;
    logic signed [WL-1:0] c_sum [NC];
    logic          its_business_time;
    logic          frame_err;

    logic          s_valid;
    logic          s_ready;
    logic [1:0]    s_data;
    logic          s_last;
    logic signed [3:0] s_csum [1];
    logic          s_bt;
    logic          s_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    class_sum_accumulator #(
        .CLASS_NUM(NC), .CLAUSES_PER_CLASS(CPC),
        .CHUNK_WIDTH(CW), .WEIGHT_LENGTH(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .clause_valid(clause_valid), .clause_ready(clause_ready),
        .clause_data(clause_data), .clause_last(clause_last),
        .c_sum(c_sum), .its_business_time(its_business_time),
        .frame_err(frame_err)
    );

    class_sum_accumulator #(
        .CLASS_NUM(1), .CLAUSES_PER_CLASS(32),
        .CHUNK_WIDTH(2), .WEIGHT_LENGTH(4)
    ) u_sat (
        .clk(clk), .rst_n(rst_n),
        .clause_valid(s_valid), .clause_ready(s_ready),
        .clause_data(s_data), .clause_last(s_last),
        .c_sum(s_csum), .its_business_time(s_bt),
        .frame_err(s_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wrapw(input int s, input int w);
        int m;
        int r;
        m = 1 << w;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Frame-level model: count accepted beats, sum clause votes per class
    int   m_n;
    int   m_sum [NC];
    logic exp_ready, exp_bt, exp_err;
    int   exp_cs [NC];

    always @(posedge clk or negedge rst_n) begin
        int s [NC];
        int n;
        int cls;
        if (!rst_n) begin
            m_n       <= 0;
            m_sum     <= '{0, 0, 0};
            exp_ready <= 1'b0;
            exp_bt    <= 1'b0;
            exp_err   <= 1'b0;
            exp_cs    <= '{0, 0, 0};
        end else begin
            s = m_sum;
            n = m_n;
            exp_ready <= 1'b1;
            if (clause_valid && exp_ready) begin
                cls = n / BEATS;
                for (int k = 0; k < CW; k++) begin
                    if (clause_data[k]) s[cls] += ((k % 2) == 0) ? 1 : -1;
                end
`ifdef CSUM_SATURATE_EN
                if (s[cls] > 127)  s[cls] = 127;
                if (s[cls] < -128) s[cls] = -128;
`endif
                if (clause_last != (n == TOTAL - 1)) exp_err <= 1'b1;
                if (n == 0) exp_bt <= 1'b0;
                n++;
                if (n == TOTAL) begin
                    n = 0;
                    for (int i = 0; i < NC; i++) exp_cs[i] <= wrapw(s[i], WL);
                    s = '{0, 0, 0};
                    exp_bt    <= 1'b1;
                    exp_ready <= 1'b0;
                end
            end
            m_n   <= n;
            m_sum <= s;
        end
    end

    // Per-cycle compare against the model, plus high-time guarantee
    int   hi_run = 0;
    logic prev_bt = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("clause_ready", clause_ready, exp_ready);
            chk("its_business_time", its_business_time, exp_bt);
            chk("frame_err", frame_err, exp_err);
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("c_sum[%0d]", i), int'(c_sum[i]), exp_cs[i]);
            end
            if (rst_n && prev_bt && !its_business_time) begin
                chk("bt_high_len_ge2", int'(hi_run >= 2), 1);
            end
            hi_run  <= its_business_time ? hi_run + 1 : 0;
            prev_bt <= its_business_time;
        end
    end

    task automatic beat(input logic [1:0] d, input logic l, input int gap);
        int t;
        if (gap > 0) begin
            clause_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        clause_valid = 1'b1;
        clause_data  = d;
        clause_last  = l;
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            if (clause_ready) break;
            t++;
        end
        chk("beat_accept_timeout", int'(t < 20), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] d [6], input logic [5:0] lm,
                              input int maxgap);
        for (int i = 0; i < 6; i++) begin
            beat(d[i], lm[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic expect_sums(input string nm, input int a, input int b,
                               input int c);
        chk({nm, "_c0"}, int'(c_sum[0]), a);
        chk({nm, "_c1"}, int'(c_sum[1]), b);
        chk({nm, "_c2"}, int'(c_sum[2]), c);
    endtask

    task automatic wait_bt();
        int t;
        t = 0;
        while (!its_business_time && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bt_wait_timeout", int'(t < 20), 1);
    endtask

    logic [1:0] fa [6];
    logic [1:0] fb [6];
    logic [1:0] fp [6];

    initial begin
        int t;
        int sat_exp;
        fa = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        fb = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        fp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        clause_valid = 1'b0;
        clause_data  = '0;
        clause_last  = 1'b0;
        s_valid = 1'b0;
        s_data  = 2'b00;
        s_last  = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", clause_ready, 0);
        chk("rst_bt", its_business_time, 0);
        chk("rst_err", frame_err, 0);
        expect_sums("rst", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(fa, 6'b100000, 0);
        chk("A_bt_next_cycle", its_business_time, 1);
        chk("A_ready_hold", clause_ready, 0);
        chk("A_err", frame_err, 0);
        expect_sums("A", 2, -2, 0);

        send_frame(fb, 6'b100000, 0);
        clause_valid = 1'b0;
        wait_bt();
        expect_sums("B", 2, 2, -2);
        repeat (2) @(posedge clk);
        #1;

        beat(fa[0], 1'b0, 0);
        beat(fa[1], 1'b0, 0);
        beat(fa[2], 1'b1, 0);
        chk("C_err_set", frame_err, 1);
        beat(fa[3], 1'b0, 0);
        beat(fa[4], 1'b0, 0);
        beat(fa[5], 1'b1, 0);
        clause_valid = 1'b0;
        wait_bt();
        expect_sums("C", 2, -2, 0);
        chk("C_err_sticky", frame_err, 1);

        for (int i = 0; i < 4; i++) beat(2'b11, 1'b0, 0);
        clause_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("D_err_cleared", frame_err, 0);
        send_frame(fp, 6'b100000, 0);
        clause_valid = 1'b0;
        wait_bt();
        expect_sums("D", 2, 2, 2);

        for (int r = 0; r < 2; r++) begin
            send_frame(fa, 6'b100000, 3);
            clause_valid = 1'b0;
            wait_bt();
            expect_sums("R", 2, -2, 0);
        end

        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 2'b01;
            s_last  = (i == 15);
            t = 0;
            while (t < 20) begin
                @(negedge clk);
                if (s_ready) break;
                t++;
            end
            chk("sat_accept_timeout", int'(t < 20), 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
`ifdef CSUM_SATURATE_EN
        sat_exp = 7;
`else
        sat_exp = 0;
`endif
        chk("sat_bt", s_bt, 1);
        chk("sat_err", s_err, 0);
        chk("sat_sum", int'(s_csum[0]), sat_exp);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
